// File: rtl/ucdp_clk_div_pkg.sv
// ----------------------------------------------------------------------------
// ucdp_clk_div_pkg
//
// Purpose:
//   Shared types and constants for the programmable even-ratio clock divider.
//
// Contents:
//   state_e        2-bit FSM state encoding (IDLE / HIGH / LOW)
//   div_default_p  divisor value held in div_q out of reset
// ----------------------------------------------------------------------------
package ucdp_clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int div_default_p = 0;

endpackage : ucdp_clk_div_pkg

// File: rtl/ucdp_clk_div.sv
// ----------------------------------------------------------------------------
// ucdp_clk_div
//
// Purpose:
//   Programmable even-ratio clock divider. Produces a registered, glitch-free,
//   50 % duty divided clock from clk_i. The high and low phases each last
//   div_i+1 clk_i cycles, so the divide factor is 2*(div_i+1). A new divisor
//   and the enable are only taken at period boundaries (IDLE->HIGH or
//   LOW->HIGH), so clk_o never produces a runt pulse outside of reset.
//   Intended to feed the clkb_i input of ucdp_clk_mux.
//
// Parameters:
//   width_p    width of div_i; divide range 2 .. 2^(width_p+1)
//
// Ports:
//   clk_i      in   1        source clock, only clock of the block
//   rst_an_i   in   1        synchronous active-low reset
//   en_i       in   1        divider enable, sampled in IDLE and at the end
//                            of each low phase
//   div_i      in   width_p  half-period minus one
//   clk_o      out  1        divided clock, straight from a flop
//   tick_o     out  1        strobe in the first cycle of each high phase
//   upd_o      out  1        strobe in the first high cycle of a period whose
//                            divisor differs from the previous period's
//   active_o   out  1        high while the FSM is not IDLE
//
// Notes:
//   A reset arriving in the middle of a high phase drops clk_o at that edge,
//   so the last high phase before reset may be shortened. This is accepted.
// ----------------------------------------------------------------------------
module ucdp_clk_div
  import ucdp_clk_div_pkg::*;
#(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               rst_an_i,
  input  logic               en_i,
  input  logic [width_p-1:0] div_i,
  output logic               clk_o,
  output logic               tick_o,
  output logic               upd_o,
  output logic               active_o
);

  localparam logic [width_p-1:0] cnt_one_lp = width_p'(1);
  localparam logic [width_p-1:0] div_rst_lp = width_p'(div_default_p);

  state_e             state_q, state_d;
  logic [width_p-1:0] cnt_q,   cnt_d;
  logic [width_p-1:0] div_q,   div_d;
  logic               clk_q,   clk_d;
  logic               tick_q,  tick_d;
  logic               upd_q,   upd_d;
  logic               active_q, active_d;

  // --------------------------------------------------------------------------
  // Next-state logic.
  // The counter holds the number of cycles still to spend in the current
  // phase after this one; it is always reloaded when it reaches zero, so it
  // never wraps. The divisor register div_q is only written when a new period
  // starts, which is what keeps a mid-period div_i change from distorting the
  // running period.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    upd_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = HIGH;
          cnt_d   = div_i;
          div_d   = div_i;
          tick_d  = 1'b1;
          upd_d   = (div_i != div_q);
        end
      end

      HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_one_lp;
        end else begin
          // Low phase reuses the divisor latched for this period.
          cnt_d   = div_q;
          state_d = LOW;
        end
      end

      LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_one_lp;
        end else if (en_i) begin
          state_d = HIGH;
          cnt_d   = div_i;
          div_d   = div_i;
          tick_d  = 1'b1;
          upd_d   = (div_i != div_q);
        end else begin
          // div_q is kept so the next enable compares against the last
          // divisor actually used.
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are computed from the next state so the flops present them in
    // the same cycle the FSM is in the corresponding state.
    clk_d    = (state_d == HIGH);
    active_d = (state_d != IDLE);
  end

  // --------------------------------------------------------------------------
  // State and output registers, synchronous active-low reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_an_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= div_rst_lp;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      upd_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      upd_q    <= upd_d;
      active_q <= active_d;
    end
  end

  assign clk_o    = clk_q;
  assign tick_o   = tick_q;
  assign upd_o    = upd_q;
  assign active_o = active_q;

  // --------------------------------------------------------------------------
  // Structural invariants of the divider.
  // --------------------------------------------------------------------------
  a_clk_matches_state : assert property (@(posedge clk_i) disable iff (!rst_an_i)
    clk_q == (state_q == HIGH));

  a_active_matches_state : assert property (@(posedge clk_i) disable iff (!rst_an_i)
    active_q == (state_q != IDLE));

  a_tick_only_high : assert property (@(posedge clk_i) disable iff (!rst_an_i)
    tick_q |-> clk_q);

  a_upd_implies_tick : assert property (@(posedge clk_i) disable iff (!rst_an_i)
    upd_q |-> tick_q);

  a_state_legal : assert property (@(posedge clk_i) disable iff (!rst_an_i)
    state_q inside {IDLE, HIGH, LOW});

endmodule : ucdp_clk_div

// File: doc/ucdp_clk_div.md
Name: ucdp_clk_div

Overview:
- Programmable even-ratio clock divider. Produces a registered, glitch-free, 50 %-duty divided clock from clk_i.
- Sits directly upstream of ucdp_clk_mux and drives its clkb_i input; clka_i carries the undivided clock.
- Divisor changes and enable/disable take effect only at period boundaries, so clk_o never produces a runt pulse except under reset.

Parameters:
- width_p, 4, width of divisor input; divide factor = 2*(div_i+1), range 2..2^(width_p+1).

Ports:
- clk_i  input  1  source clock; only clock of the block.
- rst_an_i  input  1  reset, synchronous, active-low.
- en_i  input  1  divider enable; sampled at period boundaries and in IDLE.
- div_i  input  width_p  half-period minus one; high and low phases each last div_i+1 clk_i cycles.
- clk_o  output  1  divided clock; driven directly from a flop, never combinational.
- tick_o  output  1  one-cycle strobe, high in the first clk_i cycle of every clk_o high phase.
- upd_o  output  1  one-cycle strobe, high in the first high cycle of a period whose divisor differs from the previous period's.
- active_o  output  1  high while state is not IDLE.

Behaviour:
- Reset: on any clk_i edge with rst_an_i=0, all of these are set: state=IDLE, cnt=0, div_q=0, clk_o=0, tick_o=0, upd_o=0, active_o=0. Reset has priority over all other inputs.
- Reset mid-period forces clk_o low at that edge; a shortened high phase is accepted and documented.
- State machine IDLE/HIGH/LOW, counter cnt[width_p-1:0] counting down:
  - IDLE: clk_o=0. If en_i=1: div_q<=div_i, cnt<=div_i, goto HIGH. clk_o=1 and tick_o=1 in the next cycle. upd_o=1 if div_i!=div_q.
  - HIGH: clk_o=1. If cnt!=0: cnt<=cnt-1. If cnt==0: cnt<=div_q, goto LOW.
  - LOW: clk_o=0. If cnt!=0: cnt<=cnt-1. If cnt==0 and en_i=1: div_q<=div_i, cnt<=div_i, goto HIGH, tick_o=1 next cycle, upd_o=1 next cycle if div_i!=div_q. If cnt==0 and en_i=0: goto IDLE.
- Latency: en_i sampled high in IDLE at edge k gives clk_o=1 from edge k+1.
- Division examples:
  - div_i=0: clk_o toggles every clk_i cycle (/2).
  - div_i=max: 2^width_p high cycles, then 2^width_p low cycles.
- en_i deasserted mid-period: the current period always completes. clk_o ends low; active_o falls one cycle after the last low cycle.
- div_i changed mid-period: ignored until the LOW->HIGH or IDLE->HIGH boundary; only the value present at the boundary edge is used.
- en_i and div_i change simultaneously at the boundary: en_i=1 loads the new div_i; en_i=0 goes to IDLE and div_q is held.
- Counter never wraps: it is reloaded at 0, and underflow is unreachable.
- tick_o and upd_o are registered, aligned with clk_o rising, and never high in IDLE or LOW.

Decomposition:
- Package ucdp_clk_div_pkg holds:
  - typedef state_e (IDLE=2'd0, HIGH=2'd1, LOW=2'd2), 2-bit.
  - localparam div_default_p=0.
- No sub-module: the counter and FSM form one flat always_ff block, with clk_o, tick_o and upd_o as flop outputs.

Test Plan:
- Reset then en_i=1, div_i=0 for 20 cycles -> clk_o 0,1,0,1,... starting one cycle after en_i; tick_o high on every clk_o high cycle; upd_o low throughout.
- div_i=2, en_i=1 -> clk_o 3 cycles high, 3 cycles low, repeating; tick_o every 6 cycles; active_o=1.
- Running at div_i=1; change div_i to 3 during a high phase -> current period stays 2 high/2 low; next period is 4 high/4 low; upd_o pulses once at that period's first high cycle.
- Running at div_i=3; drop en_i in the 2nd high cycle -> high phase completes (4 cycles), low phase completes (4 cycles), then IDLE with clk_o=0 and active_o=0 one cycle later.
- Running at div_i=2; assert rst_an_i=0 for one cycle during a high phase -> at that edge clk_o, tick_o, upd_o and active_o=0; with en_i=1 after release, clk_o rises one cycle after rst_an_i=1.
- div_i=4'hF (width_p=4) -> 16 high, 16 low; cnt reloads to 15 without wrap; no glitch on clk_o between phases.
